// File: rtl/io_controller.sv
// IO controller: bridges d_bus to a 16-address peripheral port and latches,
// prioritises and vectors external interrupt requests.
module io_controller #(
    parameter int          NUM_INTS     = 4,
    parameter logic [15:0] VECTOR_BASE  = 16'hFFF0,
    parameter logic [3:0]  INT_CLR_ADDR = 4'hF
) (
    input  logic                clk,
    input  logic                rst,
    inout  wire  [15:0]         d_bus,
    input  logic [3:0]          io_addr,
    input  logic                io_addr_read,
    input  logic                io_read,
    input  logic                io_write,
    input  logic                io_push,
    input  logic                io_store_retaddr,
    input  logic                io_push_retaddr,
    input  logic                io_push_ints,
    input  logic                io_push_int_addr,
    output logic                io_interrupt,
    input  logic [NUM_INTS-1:0] int_req,
    output logic [3:0]          ext_addr,
    output logic [15:0]         ext_wdata,
    output logic                ext_we,
    output logic                ext_re,
    input  logic [15:0]         ext_rdata
);

    logic [3:0]          addr_reg;
    logic [15:0]         rd_buf;
    logic [15:0]         retaddr;
    logic [NUM_INTS-1:0] pending;
    logic [NUM_INTS-1:0] pending_next;
    logic [NUM_INTS-1:0] sync1;
    logic [NUM_INTS-1:0] sync2;
    logic [NUM_INTS-1:0] sync_prev;
    logic [NUM_INTS-1:0] edge_det;
    logic [NUM_INTS-1:0] ack_mask;
    logic [NUM_INTS-1:0] clr_mask;
    logic                irq_reg;
    logic                found;
    logic [15:0]         vec_idx;
    logic [15:0]         pending_ext;
    logic [15:0]         bus_val;
    logic                bus_en;
    logic                clr_write;

    // Peripheral port
    assign ext_addr  = io_addr_read ? io_addr : addr_reg;
    assign ext_re    = io_read;
    assign clr_write = io_write && (ext_addr == INT_CLR_ADDR);
    assign ext_we    = io_write && !clr_write;
    // Gated so the peripheral never sees a floating bus outside a write.
    assign ext_wdata = io_write ? d_bus : 16'h0000;

    // Interrupt capture and acknowledge
    assign edge_det = sync2 & ~sync_prev;

    // NOTE: every variable assigned in always_comb gets a default first so no
    // path through the block leaves it unassigned (which would infer a latch).
    always_comb begin
        ack_mask = '0;
        vec_idx  = 16'h0000;
        found    = 1'b0;
        for (int i = 0; i < NUM_INTS; i++) begin
            if (pending[i] && !found) begin
                ack_mask[i] = io_push_int_addr;
                vec_idx     = 16'(i);
                found       = 1'b1;
            end
        end
    end

    assign clr_mask     = clr_write ? d_bus[NUM_INTS-1:0] : '0;
    // A fresh edge beats a same-cycle clear or acknowledge.
    assign pending_next = (pending & ~(clr_mask | ack_mask)) | edge_det;

    always_comb begin
        pending_ext                 = 16'h0000;
        pending_ext[NUM_INTS-1:0] = pending;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_reg  <= 4'h0;
            rd_buf    <= 16'h0000;
            retaddr   <= 16'h0000;
            pending   <= '0;
            sync1     <= '0;
            sync2     <= '0;
            sync_prev <= '0;
            irq_reg   <= 1'b0;
        end else begin
            if (io_addr_read)     addr_reg <= io_addr;
            if (io_read)          rd_buf   <= ext_rdata;
            if (io_store_retaddr) retaddr  <= d_bus;
            sync1     <= int_req;
            sync2     <= sync1;
            sync_prev <= sync2;
            pending   <= pending_next;
            irq_reg   <= |pending_next;
        end
    end

    assign io_interrupt = irq_reg;

    // Single bus source, fixed priority; released asynchronously by rst.
    always_comb begin
        bus_en  = !rst && (io_push_int_addr || io_push_retaddr || io_push || io_push_ints);
        bus_val = 16'h0000;
        if (io_push_int_addr)     bus_val = VECTOR_BASE + vec_idx;
        else if (io_push_retaddr) bus_val = retaddr;
        else if (io_push)         bus_val = rd_buf;
        else if (io_push_ints)    bus_val = pending_ext;
    end

    assign d_bus = bus_en ? bus_val : 16'hzzzz;

endmodule

// File: tb/tb_io_controller.sv
// Self-checking bench for io_controller: directed scenarios with literal
// expectations, then randomized traffic compared against a behavioural model.
module tb_io_controller;

    localparam int          NI  = 4;
    localparam logic [15:0] VB  = 16'hFFF0;
    localparam logic [3:0]  CLR = 4'hF;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    wire  [15:0]   d_bus;
    logic [15:0]   tb_bus = 16'h0000;
    logic          tb_bus_en = 1'b0;
    logic [3:0]    io_addr = 4'h0;
    logic          io_addr_read = 1'b0;
    logic          io_read = 1'b0;
    logic          io_write = 1'b0;
    logic          io_push = 1'b0;
    logic          io_store_retaddr = 1'b0;
    logic          io_push_retaddr = 1'b0;
    logic          io_push_ints = 1'b0;
    logic          io_push_int_addr = 1'b0;
    logic          io_interrupt;
    logic [NI-1:0] int_req = '0;
    logic [3:0]    ext_addr;
    logic [15:0]   ext_wdata;
    logic          ext_we;
    logic          ext_re;
    logic [15:0]   ext_rdata = 16'h0000;

    assign d_bus = tb_bus_en ? tb_bus : 16'hzzzz;

    io_controller #(.NUM_INTS(NI), .VECTOR_BASE(VB), .INT_CLR_ADDR(CLR)) dut (
        .clk(clk), .rst(rst), .d_bus(d_bus),
        .io_addr(io_addr), .io_addr_read(io_addr_read),
        .io_read(io_read), .io_write(io_write), .io_push(io_push),
        .io_store_retaddr(io_store_retaddr), .io_push_retaddr(io_push_retaddr),
        .io_push_ints(io_push_ints), .io_push_int_addr(io_push_int_addr),
        .io_interrupt(io_interrupt), .int_req(int_req),
        .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_we(ext_we),
        .ext_re(ext_re), .ext_rdata(ext_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [3:0]    m_addr;
    logic [15:0]   m_rdbuf;
    logic [15:0]   m_ret;
    logic [NI-1:0] m_pend;
    logic [NI-1:0] req_hist[$];

    // Request sample taken d clock edges ago (1 = most recent); zero before reset release.
    function automatic logic [NI-1:0] hist_at(input int d);
        if (req_hist.size() >= d) return req_hist[req_hist.size() - d];
        return '0;
    endfunction

    function automatic logic [3:0] eff_addr();
        return io_addr_read ? io_addr : m_addr;
    endfunction

    function automatic logic [15:0] exp_bus();
        logic [15:0] v;
        bit          hit;
        v   = 16'h0000;
        hit = 1'b0;
        if (io_push_int_addr) begin
            v = VB;
            for (int i = 0; i < NI; i++)
                if (m_pend[i] && !hit) begin
                    v   = VB + 16'(i);
                    hit = 1'b1;
                end
        end else if (io_push_retaddr) v = m_ret;
        else if (io_push)             v = m_rdbuf;
        else if (io_push_ints)        v = {{(16-NI){1'b0}}, m_pend};
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        logic [NI-1:0] set_m, ack_m, clr_m;
        if (rst) begin
            m_addr  <= 4'h0;
            m_rdbuf <= 16'h0000;
            m_ret   <= 16'h0000;
            m_pend  <= '0;
            req_hist.delete();
        end else begin
            // An edge is seen two samples after the request line rises.
            set_m = hist_at(2) & ~hist_at(3);
            ack_m = io_push_int_addr ? (m_pend & (~m_pend + 1'b1)) : '0;
            clr_m = (io_write && eff_addr() == CLR) ? tb_bus[NI-1:0] : '0;
            m_pend <= (m_pend & ~(ack_m | clr_m)) | set_m;
            if (io_addr_read)     m_addr  <= io_addr;
            if (io_read)          m_rdbuf <= ext_rdata;
            if (io_store_retaddr) m_ret   <= tb_bus;
            req_hist.push_back(int_req);
            if (req_hist.size() > 4) void'(req_hist.pop_front());
        end
    end

    always @(negedge clk) begin
        if (cmp_on && !rst) begin
            check("m_ext_addr", ext_addr, eff_addr());
            check("m_ext_re", ext_re, io_read);
            check("m_ext_we", ext_we, io_write && eff_addr() != CLR);
            check("m_irq", io_interrupt, m_pend != '0);
            if (io_write) check("m_ext_wdata", ext_wdata, tb_bus);
            if (io_push || io_push_retaddr || io_push_ints || io_push_int_addr)
                check("m_d_bus", d_bus, exp_bus());
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        io_addr_read = 1'b0; io_read = 1'b0; io_write = 1'b0; io_push = 1'b0;
        io_store_retaddr = 1'b0; io_push_retaddr = 1'b0; io_push_ints = 1'b0;
        io_push_int_addr = 1'b0; tb_bus_en = 1'b0;
    endtask

    // Drives two patterns from the bench; a released bus reads them back unchanged.
    task automatic check_released(input string name);
        tb_bus_en = 1'b1;
        tb_bus = 16'hA5A5; #1 check(name, d_bus, 16'hA5A5);
        tb_bus = 16'h5A5A; #1 check(name, d_bus, 16'h5A5A);
        tb_bus_en = 1'b0;
    endtask

    task automatic wait_irq(input string name);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 4 && !got; k++) begin
            if (io_interrupt === 1'b1) got = 1'b1;
            else step();
        end
        check(name, got, 1'b1);
    endtask

    task automatic read_ints(input string name, input logic [15:0] exp);
        idle(); io_push_ints = 1'b1; #1 check(name, d_bus, exp);
        step(); idle();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset
        #1 rst = 1'b1;
        #2;
        check("rst_irq", io_interrupt, 1'b0);
        check("rst_we", ext_we, 1'b0);
        check("rst_re", ext_re, 1'b0);
        check("rst_addr", ext_addr, 4'h0);
        check("rst_wdata", ext_wdata, 16'h0000);
        check_released("rst_bus_z");
        step(); step();
        rst = 1'b0;
        cmp_on = 1'b1;
        step();
        check_released("post_rst_bus_z");
        check("post_rst_irq", io_interrupt, 1'b0);

        // IO read, one-cycle read-to-push latency
        io_addr = 4'd3; io_addr_read = 1'b1; io_read = 1'b1; ext_rdata = 16'hBEEF;
        #1 check("rd_re", ext_re, 1'b1);
        check("rd_addr", ext_addr, 4'd3);
        step();
        io_read = 1'b0; io_push = 1'b1; ext_rdata = 16'h0000;
        #1 check("rd_push", d_bus, 16'hBEEF);
        step(); idle();

        // IO write, normal and to the clear address
        io_write = 1'b1; io_addr = 4'd5; io_addr_read = 1'b1;
        tb_bus = 16'h1234; tb_bus_en = 1'b1;
        #1 check("wr_we", ext_we, 1'b1);
        check("wr_addr", ext_addr, 4'd5);
        check("wr_data", ext_wdata, 16'h1234);
        step();
        io_addr = CLR;
        #1 check("wr_clr_we", ext_we, 1'b0);
        step(); idle();

        // Interrupt priority and vectoring
        int_req = 4'b0110;
        wait_irq("irq_rise");
        int_req = 4'b0000;
        io_push_int_addr = 1'b1;
        #1 check("vec_first", d_bus, 16'hFFF1);
        step();
        read_ints("pend_after_ack1", 16'h0004);
        io_push_int_addr = 1'b1;
        #1 check("vec_second", d_bus, 16'hFFF2);
        step(); idle();
        #1 check("irq_fall", io_interrupt, 1'b0);

        // Return address
        io_store_retaddr = 1'b1; tb_bus = 16'h0042; tb_bus_en = 1'b1;
        step(); idle(); step();
        io_push_retaddr = 1'b1;
        #1 check("retaddr", d_bus, 16'h0042);
        step(); idle();

        // Set/clear collision on bit 0
        int_req[0] = 1'b1;
        wait_irq("irq0_rise");
        int_req[0] = 1'b0;
        step(); step(); step();
        int_req[0] = 1'b1;           // sampled at next edge, detected two edges later
        step(); step();
        io_push_int_addr = 1'b1;
        #1 check("vec_collide", d_bus, 16'hFFF0);
        step(); idle();
        #1 check("collide_irq", io_interrupt, 1'b1);
        read_ints("collide_pend", 16'h0001);
        io_write = 1'b1; io_addr = CLR; io_addr_read = 1'b1;
        tb_bus = 16'h0001; tb_bus_en = 1'b1;
        step(); idle();
        read_ints("clr_pend", 16'h0000);
        step(); step(); step();
        read_ints("level_no_reset", 16'h0000);
        int_req[0] = 1'b0;

        // Asynchronous reset in mid-sequence
        int_req[3] = 1'b1;
        wait_irq("irq3_rise");
        int_req[3] = 1'b0;
        io_push_retaddr = 1'b1;
        #1 check("pre_rst_push", d_bus, 16'h0042);
        #1 rst = 1'b1;
        #1 check("mid_rst_irq", io_interrupt, 1'b0);
        check_released("mid_rst_bus_z");
        idle();
        step();
        rst = 1'b0;
        step();
        read_ints("pend_lost", 16'h0000);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            int op;
            idle();
            for (int b = 0; b < NI; b++)
                if ($urandom_range(7) == 0) int_req[b] = ~int_req[b];
            ext_rdata    = 16'($urandom);
            io_addr      = 4'($urandom);
            io_addr_read = 1'($urandom);
            op = $urandom_range(9);
            case (op)
                1: io_read = 1'b1;
                2: begin io_push = 1'b1; io_read = 1'($urandom); end
                3: begin io_write = 1'b1; tb_bus = 16'($urandom); tb_bus_en = 1'b1; end
                4: begin
                    io_write = 1'b1; io_addr = CLR; io_addr_read = 1'b1;
                    tb_bus = 16'($urandom); tb_bus_en = 1'b1;
                end
                5: begin io_store_retaddr = 1'b1; tb_bus = 16'($urandom); tb_bus_en = 1'b1; end
                6: io_push_retaddr = 1'b1;
                7: io_push_ints = 1'b1;
                8: io_push_int_addr = 1'b1;
                9: begin
                    io_push          = 1'($urandom);
                    io_push_retaddr  = 1'($urandom);
                    io_push_ints     = 1'($urandom);
                    io_push_int_addr = 1'($urandom);
                    if (!(io_push || io_push_retaddr || io_push_ints || io_push_int_addr))
                        io_push_ints = 1'b1;
                end
                default: ;
            endcase
            step();
        end
        idle();
        int_req = '0;
        step();

        cmp_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
